// File: rtl/arb_pkg.sv
// Shared types and constants for the priority arbiter.
package arb_pkg;

  // Arbiter FSM state, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Default number of requesters.
  localparam int DEFAULT_N = 8;

  // Width of the saturating hold counter.
  localparam int HOLD_W = 8;

endpackage

// File: rtl/priority_arbiter_if.sv
// Requester-side bus of the priority arbiter.
//
// Handshake: a requester raises req[k] and keeps it high for as long as it
// wants the resource. The grant is valid while gnt_valid=1, and gnt/gnt_id
// then name the single owner. The owner gives the resource back either by
// dropping req[k] or by pulsing done for one cycle. Only the owner's req bit
// and done are looked at during a grant. Every release is followed by one
// GAP cycle with no grant, then an IDLE pick cycle.
interface priority_arbiter_if #(
  parameter int N = arb_pkg::DEFAULT_N
);
  localparam int IW = $clog2(N);

  logic [N-1:0]        req;
  logic                done;
  logic [N-1:0]        gnt;
  logic                gnt_valid;
  logic [IW-1:0]       gnt_id;
  logic                idle;
  arb_pkg::arb_state_t state;  // FSM state, exposed for debug

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  idle,
    input  state
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output idle,
    output state
  );

endinterface

// File: rtl/priority_pick.sv
// Combinational highest-set-bit picker: one-hot, index and any-flag.
module priority_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Ascending scan so the highest set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/priority_arbiter.sv
// Sequential arbiter: fixed-priority or round-robin pick, grant held until
// release (done, request drop or timeout), one-cycle turnaround gap.
module priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter bit RR       = 1'b1,
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst,
  priority_arbiter_if.slave bus
);

  localparam int                IW         = $clog2(N);
  localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  arb_state_t        state_q, state_n;
  logic [N-1:0]      gnt_q, gnt_n;
  logic              gnt_valid_q;
  logic [IW-1:0]     gnt_id_q, gnt_id_n;
  logic [IW-1:0]     last_q, last_n;
  logic [HOLD_W-1:0] hold_q, hold_n;

  logic [N-1:0]  below_last;
  logic [N-1:0]  masked_req;
  logic [N-1:0]  m_oh, r_oh, win_oh;
  logic [IW-1:0] m_idx, r_idx, win_idx;
  logic          m_any, r_any;
  logic          release_c;

  // Round-robin mask: only requesters strictly below the previous owner.
  always_comb begin
    below_last = '0;
    for (int i = 0; i < N; i++) begin
      below_last[i] = (i < int'(last_q));
    end
    masked_req = RR ? (bus.req & below_last) : '0;
  end

  priority_pick #(.N(N)) u_pick_masked (
    .vec    (masked_req),
    .onehot (m_oh),
    .idx    (m_idx),
    .any    (m_any)
  );

  priority_pick #(.N(N)) u_pick_raw (
    .vec    (bus.req),
    .onehot (r_oh),
    .idx    (r_idx),
    .any    (r_any)
  );

  // Prefer the masked winner; wrap around to the raw winner when empty.
  always_comb begin
    win_oh  = m_any ? m_oh  : r_oh;
    win_idx = m_any ? m_idx : r_idx;
  end

  // Any release cause ends the grant; several at once still give one GAP.
  always_comb begin
    release_c = bus.done
              | ~bus.req[gnt_id_q]
              | (TIMEOUT_EN && (hold_q == HOLD_LIMIT));
  end

  // Next-state and next-output logic of the arbiter FSM.
  always_comb begin
    state_n  = state_q;
    gnt_n    = gnt_q;
    gnt_id_n = gnt_id_q;
    last_n   = last_q;
    hold_n   = hold_q;
    case (state_q)
      IDLE: begin
        if (r_any) begin
          gnt_n    = win_oh;
          gnt_id_n = win_idx;
          last_n   = win_idx;
          hold_n   = HOLD_W'(1);
          state_n  = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          gnt_n   = '0;
          hold_n  = '0;
          state_n = GAP;
        end else if (hold_q != '1) begin
          hold_n = hold_q + HOLD_W'(1);
        end
      end
      GAP: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_n;
      gnt_q       <= gnt_n;
      gnt_valid_q <= |gnt_n;
      gnt_id_q    <= gnt_id_n;
      last_q      <= last_n;
      hold_q      <= hold_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.idle      = (state_q == IDLE) && (bus.req == '0);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed testbench for priority_arbiter: round-robin, fixed-priority and
// short-timeout instances share one clock and reset.
module tb_priority_arbiter;
  import arb_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [2:0] exp_q[$];

  priority_arbiter_if #(.N(8)) ba ();  // RR=1, MAX_HOLD=16
  priority_arbiter_if #(.N(8)) bb ();  // RR=0, MAX_HOLD=16
  priority_arbiter_if #(.N(8)) bc ();  // RR=1, MAX_HOLD=4

  priority_arbiter #(.N(8), .RR(1'b1), .MAX_HOLD(16)) dut_rr (.clk(clk), .rst(rst), .bus(ba));
  priority_arbiter #(.N(8), .RR(1'b0), .MAX_HOLD(16)) dut_fx (.clk(clk), .rst(rst), .bus(bb));
  priority_arbiter #(.N(8), .RR(1'b1), .MAX_HOLD(4))  dut_mh (.clk(clk), .rst(rst), .bus(bc));

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    ba.req = '0; ba.done = 1'b0;
    bb.req = '0; bb.done = 1'b0;
    bc.req = '0; bc.done = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    n_vec++; if (ba.gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got %h want 00", ba.gnt); end
    n_vec++; if (ba.gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_gnt_valid got %b want 0", ba.gnt_valid); end
    n_vec++; if (ba.gnt_id !== 3'd0) begin n_err++; $display("FAIL reset_gnt_id got %0d want 0", ba.gnt_id); end
    n_vec++; if (ba.state !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want IDLE", ba.state); end
    n_vec++; if (ba.idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b want 1", ba.idle); end
    ba.req = 8'h04;
    #1;
    n_vec++; if (ba.idle !== 1'b0) begin n_err++; $display("FAIL reset_idle_follows_req got %b want 0", ba.idle); end
    ba.req = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_first_pick();
    clear_inputs();
    do_reset();
    ba.req = 8'hA0;
    #1;
    n_vec++; if (ba.idle !== 1'b0) begin n_err++; $display("FAIL first_idle got %b want 0", ba.idle); end
    n_vec++; if (ba.gnt !== 8'h00) begin n_err++; $display("FAIL first_gnt_before_edge got %h want 00", ba.gnt); end
    step();
    n_vec++; if (ba.gnt !== 8'h80) begin n_err++; $display("FAIL first_gnt got %h want 80", ba.gnt); end
    n_vec++; if (ba.gnt_id !== 3'd7) begin n_err++; $display("FAIL first_gnt_id got %0d want 7", ba.gnt_id); end
    n_vec++; if (ba.gnt_valid !== 1'b1) begin n_err++; $display("FAIL first_gnt_valid got %b want 1", ba.gnt_valid); end
    n_vec++; if (ba.idle !== 1'b0) begin n_err++; $display("FAIL first_idle_grant got %b want 0", ba.idle); end
    ba.req = '0;
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_id;
    logic [7:0] exp_oh;
    clear_inputs();
    do_reset();
    exp_q = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    ba.req = 8'hFF;
    step();
    while (exp_q.size() > 0) begin
      exp_id = exp_q.pop_front();
      exp_oh = 8'd1 << exp_id;
      for (int c = 0; c < 3; c++) begin
        n_vec++; if (ba.gnt !== exp_oh) begin n_err++; $display("FAIL rr_gnt cycle %0d got %h want %h", c, ba.gnt, exp_oh); end
        n_vec++; if (ba.gnt_id !== exp_id) begin n_err++; $display("FAIL rr_gnt_id cycle %0d got %0d want %0d", c, ba.gnt_id, exp_id); end
        if (c == 2) ba.done = 1'b1;
        step();
      end
      ba.done = 1'b0;
      n_vec++; if (ba.state !== GAP) begin n_err++; $display("FAIL rr_gap_state got %0d want GAP", ba.state); end
      n_vec++; if (ba.gnt !== 8'h00) begin n_err++; $display("FAIL rr_gap_gnt got %h want 00", ba.gnt); end
      step();
      n_vec++; if (ba.state !== IDLE) begin n_err++; $display("FAIL rr_idle_state got %0d want IDLE", ba.state); end
      n_vec++; if (ba.gnt_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle_gnt_valid got %b want 0", ba.gnt_valid); end
      step();
    end
    ba.req = '0;
    step();
    step();
  endtask

  task automatic test_fixed();
    clear_inputs();
    do_reset();
    bb.req = 8'hFF;
    step();
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 3; c++) begin
        n_vec++; if (bb.gnt !== 8'h80) begin n_err++; $display("FAIL fixed_gnt grant %0d got %h want 80", g, bb.gnt); end
        n_vec++; if (bb.gnt_id !== 3'd7) begin n_err++; $display("FAIL fixed_gnt_id grant %0d got %0d want 7", g, bb.gnt_id); end
        if (c == 2) bb.done = 1'b1;
        step();
      end
      bb.done = 1'b0;
      n_vec++; if (bb.gnt !== 8'h00) begin n_err++; $display("FAIL fixed_gap_gnt got %h want 00", bb.gnt); end
      step();
      step();
    end
    bb.req = '0;
    step();
    step();
  endtask

  task automatic test_timeout();
    clear_inputs();
    do_reset();
    bc.req = 8'h01;
    step();
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        n_vec++; if (bc.gnt !== 8'h01) begin n_err++; $display("FAIL timeout_gnt period %0d cycle %0d got %h want 01", p, c, bc.gnt); end
        n_vec++; if (bc.state !== GRANT) begin n_err++; $display("FAIL timeout_state period %0d cycle %0d got %0d want GRANT", p, c, bc.state); end
        step();
      end
      n_vec++; if (bc.gnt !== 8'h00) begin n_err++; $display("FAIL timeout_gap_gnt got %h want 00", bc.gnt); end
      n_vec++; if (bc.state !== GAP) begin n_err++; $display("FAIL timeout_gap_state got %0d want GAP", bc.state); end
      step();
      n_vec++; if (bc.gnt !== 8'h00) begin n_err++; $display("FAIL timeout_idle_gnt got %h want 00", bc.gnt); end
      n_vec++; if (bc.state !== IDLE) begin n_err++; $display("FAIL timeout_idle_state got %0d want IDLE", bc.state); end
      step();
    end
    bc.req = '0;
    step();
    step();
  endtask

  task automatic test_simultaneous_release();
    clear_inputs();
    do_reset();
    ba.req = 8'h0A;
    step();
    n_vec++; if (ba.gnt !== 8'h08) begin n_err++; $display("FAIL sim_owner3 got %h want 08", ba.gnt); end
    ba.req = 8'h8A;
    step();
    n_vec++; if (ba.gnt !== 8'h08) begin n_err++; $display("FAIL sim_nonowner_ignored got %h want 08", ba.gnt); end
    ba.req  = 8'h02;
    ba.done = 1'b1;
    step();
    ba.done = 1'b0;
    n_vec++; if (ba.state !== GAP) begin n_err++; $display("FAIL sim_gap_state got %0d want GAP", ba.state); end
    n_vec++; if (ba.gnt !== 8'h00) begin n_err++; $display("FAIL sim_gap_gnt got %h want 00", ba.gnt); end
    n_vec++; if (ba.gnt_id !== 3'd3) begin n_err++; $display("FAIL sim_gap_id_hold got %0d want 3", ba.gnt_id); end
    step();
    n_vec++; if (ba.state !== IDLE) begin n_err++; $display("FAIL sim_single_gap got %0d want IDLE", ba.state); end
    n_vec++; if (ba.gnt !== 8'h00) begin n_err++; $display("FAIL sim_idle_gnt got %h want 00", ba.gnt); end
    step();
    n_vec++; if (ba.gnt !== 8'h02) begin n_err++; $display("FAIL sim_next_gnt got %h want 02", ba.gnt); end
    n_vec++; if (ba.gnt_id !== 3'd1) begin n_err++; $display("FAIL sim_next_id got %0d want 1", ba.gnt_id); end
    ba.req = '0;
    step();
    step();
    ba.done = 1'b1;
    step();
    ba.done = 1'b0;
    n_vec++; if (ba.state !== IDLE) begin n_err++; $display("FAIL sim_done_in_idle_state got %0d want IDLE", ba.state); end
    n_vec++; if (ba.gnt !== 8'h00) begin n_err++; $display("FAIL sim_done_in_idle_gnt got %h want 00", ba.gnt); end
    n_vec++; if (ba.idle !== 1'b1) begin n_err++; $display("FAIL sim_done_in_idle_idle got %b want 1", ba.idle); end
  endtask

  task automatic test_reset_mid_grant();
    clear_inputs();
    do_reset();
    ba.req = 8'h10;
    step();
    n_vec++; if (ba.gnt !== 8'h10) begin n_err++; $display("FAIL rstmid_gnt got %h want 10", ba.gnt); end
    step();
    n_vec++; if (ba.gnt_id !== 3'd4) begin n_err++; $display("FAIL rstmid_gnt_id got %0d want 4", ba.gnt_id); end
    rst    = 1'b1;
    ba.req = 8'h11;
    step();
    n_vec++; if (ba.gnt !== 8'h00) begin n_err++; $display("FAIL rstmid_after_gnt got %h want 00", ba.gnt); end
    n_vec++; if (ba.gnt_id !== 3'd0) begin n_err++; $display("FAIL rstmid_after_id got %0d want 0", ba.gnt_id); end
    n_vec++; if (ba.gnt_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after_valid got %b want 0", ba.gnt_valid); end
    n_vec++; if (ba.state !== IDLE) begin n_err++; $display("FAIL rstmid_after_state got %0d want IDLE", ba.state); end
    rst = 1'b0;
    step();
    n_vec++; if (ba.gnt !== 8'h10) begin n_err++; $display("FAIL rstmid_rr_cleared got %h want 10", ba.gnt); end
    n_vec++; if (ba.gnt_id !== 3'd4) begin n_err++; $display("FAIL rstmid_rr_cleared_id got %0d want 4", ba.gnt_id); end
    ba.req = '0;
    step();
    step();
  endtask

  // Test sequence and final report.
  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_first_pick();
    test_round_robin();
    test_fixed();
    test_timeout();
    test_simultaneous_release();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
